divisor: RTL and testbench
==========================

// Module: divisor
// PURPOSE
//  Sequential unsigned integer divider (restoring shift-subtract, one quotient bit per clock).
//  Computes S = A / B and R = A % B.
//  Operation starts automatically on release of reset; result is held until the next reset.
//  Used as a small arithmetic leaf block; no handshake is required by its users.
// PARAMETERS
//  WIDTH  4  operand/result width in bits (A, B, S, R)
// PORTS
//  clk    in   1      single clock, rising-edge
//  reset  in   1      asynchronous, active-low reset (0 = reset, 1 = run)
//  A      in   WIDTH  dividend, unsigned
//  B      in   WIDTH  divisor, unsigned
//  S      out  WIDTH  quotient, registered
//  R      out  WIDTH  remainder, registered
// BEHAVIOUR
//  - reset=0 (async, immediate): S=0, R=0, internal quotient/remainder/count regs =0, state=LOAD.
//  - FSM states: LOAD -> CALC -> DONE.
//    LOAD: first rising edge with reset=1 captures A, B into operand regs;
//          clears partial remainder; count=WIDTH-1; -> CALC.
//    CALC: each edge shifts {rem,dvd} left by 1; if shifted rem >= B, rem -= B and quotient bit = 1, else 0;
//          count decrements; after WIDTH iterations -> DONE.
//    DONE: holds; stays until reset=0. No auto-restart.
//  - S and R are written once, on the edge that completes the last CALC iteration
//    (edge WIDTH+1 after reset release; 5 edges for WIDTH=4).
//    Before that they stay 0.
//  - Latency: WIDTH+1 rising edges from reset deassert to valid S/R.
//  - A and B are sampled only in LOAD; changes during CALC/DONE are ignored.
//  - Partial remainder register is WIDTH+1 bits wide to hold the shifted value before compare.
//    The final R always fits WIDTH bits.
//  - B=0: no subtraction guard needed; the algorithm naturally yields S = all ones, R = A.
//    This result is required.
//  - A<B: S=0, R=A.  A=0: S=0, R=0.
//  - Reset asserted mid-CALC: aborts immediately, outputs 0.
//    The next release restarts from LOAD with fresh A, B.
//  - Reset pulses shorter than one clock are honoured (async clear).
// CONFIGURATION
//  DIVISOR_DONE_EN defined:
//    - adds output port `done` (1 bit).
//    - done=0 in reset, LOAD and CALC.
//    - done goes 1 on the same edge S/R become valid and stays 1 in DONE.
//  DIVISOR_DONE_EN undefined:
//    - no `done` port.
//    - timing is identical; users rely on the fixed WIDTH+1 latency.
// TESTING
//  - A=15, B=3; release reset for 5 clk -> S=5, R=0 after 5th edge.
//    Reset low -> S=0, R=0 immediately (async).
//  - Repeat the 15/3 reset pulse train 6 times (5 clk high / 5 clk low).
//    S=5, R=0 every pass; 0 during every low phase.
//  - A=13, B=4 -> S=3, R=1.  A=2, B=7 -> S=0, R=2.  A=0, B=5 -> S=0, R=0.
//  - A=9, B=0 -> S=15, R=9.
//  - A=12, B=5; change A to 1 two edges after release -> still S=2, R=2.
//  - A=15, B=1; assert reset at edge 3 -> S=R=0 at once.
//    Re-release -> S=15, R=0 after 5 edges; with DIVISOR_DONE_EN, done rises on that edge.

Source files
------------

// File: rtl/divisor.sv
// Sequential restoring divider: S = A / B, R = A % B, one quotient bit per clock.
// Starts on reset release and holds the result until the next reset. `DIVISOR_DONE_EN adds a done output.
module divisor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] R
`ifdef DIVISOR_DONE_EN
  ,
  output logic             done
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] LOAD = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend, shifted out MSB-first; quotient shifts in at LSB
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] r_q, r_d;

  // Shifted partial remainder needs one extra bit before the compare.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] dvd_nx;

  // rem < B always holds before the shift, so the borrow out of the
  // WIDTH+1-bit subtract is exactly the (rem_sh < B) condition.
  assign rem_sh = {rem_q, dvd_q[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dvs_q};
  assign ge     = ~diff[WIDTH];
  assign rem_nx = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign dvd_nx = {dvd_q[WIDTH-2:0], ge};

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    r_d     = r_q;
    case (state_q)
      LOAD: begin
        dvd_d   = A;
        dvs_d   = B;
        rem_d   = '0;
        cnt_d   = CW'(WIDTH - 1);
        state_d = CALC;
      end
      CALC: begin
        dvd_d = dvd_nx;
        rem_d = rem_nx;
        if (cnt_q == '0) begin
          state_d = DONE;
          s_d     = dvd_nx;
          r_d     = rem_nx;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LOAD;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      s_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      r_q     <= r_d;
    end
  end

  assign S = s_q;
  assign R = r_q;

`ifdef DIVISOR_DONE_EN
  assign done = (state_q == DONE);
`endif

endmodule

// File: tb/tb_divisor.sv
// Self-checking bench for divisor: directed and random operands against an arithmetic model,
// reset pulse train, operand change during calculation, and mid-calculation abort.
module tb_divisor;
  localparam int W   = 4;
  localparam int LAT = W + 1;

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] A     = '0;
  logic [W-1:0] B     = '0;
  wire  [W-1:0] S;
  wire  [W-1:0] R;

  int n_cmp = 0;
  int n_err = 0;

`ifdef DIVISOR_DONE_EN
  wire done;
  divisor #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .A(A), .B(B), .S(S), .R(R), .done(done));
`else
  divisor #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .A(A), .B(B), .S(S), .R(R));
`endif

  always #5 clk = ~clk;

  // Reference: integer division; B=0 yields all-ones quotient and remainder A.
  function automatic void ref_div(input int a, input int b, output int s, output int r);
    if (b == 0) begin
      s = (1 << W) - 1;
      r = a;
    end else begin
      s = a / b;
      r = a % b;
    end
  endfunction

  task automatic start_run(input int a, input int b);
    @(negedge clk);
    reset = 1'b0;
    A = W'(a);
    B = W'(b);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    A = 4'd15;
    B = 4'd3;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (S !== '0 || R !== '0) begin
      n_err++;
      $display("FAIL reset_state: S=%0d R=%0d expected S=0 R=0", S, R);
    end
`ifdef DIVISOR_DONE_EN
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_done: done=%0b expected 0", done);
    end
`endif
  endtask

  task automatic test_divide(input int n_rand);
    int ta[9] = '{15, 13, 2, 0, 9, 15, 1, 15, 14};
    int tb[9] = '{3, 4, 7, 5, 0, 15, 15, 0, 1};
    int a, b, es, er;
    for (int i = 0; i < 9 + n_rand; i++) begin
      if (i < 9) begin
        a = ta[i];
        b = tb[i];
      end else begin
        a = int'($urandom_range(0, (1 << W) - 1));
        b = int'($urandom_range(0, (1 << W) - 1));
      end
      ref_div(a, b, es, er);
      start_run(a, b);
      for (int e = 1; e <= LAT + 2; e++) begin
        @(posedge clk);
        #1;
        n_cmp++;
        if (e < LAT) begin
          if (S !== '0 || R !== '0) begin
            n_err++;
            $display("FAIL early_out a=%0d b=%0d edge=%0d: S=%0d R=%0d expected 0/0", a, b, e, S, R);
          end
        end else if (S !== W'(es) || R !== W'(er)) begin
          n_err++;
          $display("FAIL divide a=%0d b=%0d edge=%0d: S=%0d R=%0d expected S=%0d R=%0d",
                   a, b, e, S, R, es, er);
        end
`ifdef DIVISOR_DONE_EN
        n_cmp++;
        if (done !== (e >= LAT)) begin
          n_err++;
          $display("FAIL done_timing a=%0d b=%0d edge=%0d: done=%0b expected %0b", a, b, e, done, e >= LAT);
        end
`endif
      end
      reset = 1'b0;
      #1;
      n_cmp++;
      if (S !== '0 || R !== '0) begin
        n_err++;
        $display("FAIL async_clear a=%0d b=%0d: S=%0d R=%0d expected 0/0", a, b, S, R);
      end
    end
  endtask

  task automatic test_pulse_train();
    A = 4'd15;
    B = 4'd3;
    for (int p = 0; p < 6; p++) begin
      @(negedge clk);
      reset = 1'b1;
      repeat (LAT) @(posedge clk);
      #1;
      n_cmp++;
      if (S !== 4'd5 || R !== 4'd0) begin
        n_err++;
        $display("FAIL pulse_high pass=%0d: S=%0d R=%0d expected S=5 R=0", p, S, R);
      end
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
        #1;
        n_cmp++;
        if (S !== '0 || R !== '0) begin
          n_err++;
          $display("FAIL pulse_low pass=%0d k=%0d: S=%0d R=%0d expected 0/0", p, k, S, R);
        end
        if (k < 4) @(negedge clk);
      end
    end
  endtask

  task automatic test_operand_change();
    start_run(12, 5);
    repeat (2) @(posedge clk);
    #1;
    A = 4'd1;
    B = W'($urandom_range(0, (1 << W) - 1));
    repeat (LAT - 2) @(posedge clk);
    #1;
    n_cmp++;
    if (S !== 4'd2 || R !== 4'd2) begin
      n_err++;
      $display("FAIL operand_change: S=%0d R=%0d expected S=2 R=2", S, R);
    end
    reset = 1'b0;
  endtask

  task automatic test_mid_abort();
    start_run(15, 1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (S !== '0 || R !== '0) begin
      n_err++;
      $display("FAIL abort_clear: S=%0d R=%0d expected 0/0", S, R);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (LAT - 1) @(posedge clk);
    #1;
    n_cmp++;
    if (S !== '0 || R !== '0) begin
      n_err++;
      $display("FAIL abort_early: S=%0d R=%0d expected 0/0 at edge %0d", S, R, LAT - 1);
    end
`ifdef DIVISOR_DONE_EN
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL abort_done_early: done=%0b expected 0", done);
    end
`endif
    @(posedge clk);
    #1;
    n_cmp++;
    if (S !== 4'd15 || R !== 4'd0) begin
      n_err++;
      $display("FAIL abort_rerun: S=%0d R=%0d expected S=15 R=0", S, R);
    end
`ifdef DIVISOR_DONE_EN
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL abort_done: done=%0b expected 1", done);
    end
`endif
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_divide(24);
    test_pulse_train();
    test_operand_change();
    test_mid_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
